led_valid_gen: RTL and testbench

Timebase generator that produces the single-cycle valid strobe consumed by the LED shift-register block (its i_valid input). It divides the system clock by one of four parameterised periods, chosen by switches. Run/stop is set by an enable switch. Period changes take effect only at a period boundary, so a shortened or truncated sweep step never occurs.

---
 rtl/led_valid_gen_pkg.sv | 22 ++
 rtl/sync_2ff.sv | 26 ++
 rtl/led_valid_gen.sv | 161 ++++++++++++++++
 tb/tb_led_valid_gen.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_valid_gen_pkg.sv
// Shared types and constants for the LED valid-strobe timebase (led_valid_gen).
package led_valid_gen_pkg;

    localparam int unsigned NB_SEL = 2;

    localparam longint unsigned DEF_PERIOD0 = 64'd1 << 14;
    localparam longint unsigned DEF_PERIOD1 = 64'd1 << 16;
    localparam longint unsigned DEF_PERIOD2 = 64'd1 << 18;
    localparam longint unsigned DEF_PERIOD3 = 64'd1 << 20;

    typedef enum logic [0:0] {
        ST_STOP,
        ST_RUN
    } state_e;

    // A period must be at least 2 clocks and its terminal count must fit the counter.
    function automatic logic period_ok(input longint unsigned period,
                                       input int unsigned nb_count);
        return (period >= 64'd2) && (period <= (64'd1 << nb_count));
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs, cleared by an active-low async reset.
module sync_2ff #(
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/led_valid_gen.sv
// Valid-strobe timebase for the LED shift register: divides clock by one of four periods.
// Optional single-step button in STOP is enabled by defining LED_VALID_GEN_STEP_EN.
module led_valid_gen
    import led_valid_gen_pkg::*;
#(
    parameter int unsigned     NB_COUNT = 32,
    parameter longint unsigned PERIOD0  = DEF_PERIOD0,
    parameter longint unsigned PERIOD1  = DEF_PERIOD1,
    parameter longint unsigned PERIOD2  = DEF_PERIOD2,
    parameter longint unsigned PERIOD3  = DEF_PERIOD3
) (
    input  logic              clock,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic [NB_SEL-1:0] i_sel,
    input  logic              i_step,
    output logic              o_valid,
    output logic              o_run,
    output logic [NB_SEL-1:0] o_sel_act
);

    if (!period_ok(PERIOD0, NB_COUNT) || !period_ok(PERIOD1, NB_COUNT) ||
        !period_ok(PERIOD2, NB_COUNT) || !period_ok(PERIOD3, NB_COUNT)) begin : g_bad_period
        $error("led_valid_gen: each PERIODx must lie in [2, 2**NB_COUNT]");
    end

    localparam logic [NB_COUNT-1:0] TERM0   = NB_COUNT'(PERIOD0 - 64'd1);
    localparam logic [NB_COUNT-1:0] TERM1   = NB_COUNT'(PERIOD1 - 64'd1);
    localparam logic [NB_COUNT-1:0] TERM2   = NB_COUNT'(PERIOD2 - 64'd1);
    localparam logic [NB_COUNT-1:0] TERM3   = NB_COUNT'(PERIOD3 - 64'd1);
    localparam logic [NB_COUNT-1:0] CNT_ONE = NB_COUNT'(1);

    logic              rst_sync_n;
    logic              en_s;
    logic [NB_SEL-1:0] sel_s;
    logic              step_rise;

    // Reset asserts at once and releases two edges later; the input
    // synchronisers see the raw reset so they are already primed on release.
    sync_2ff #(
        .Width (1)
    ) u_rst_sync (
        .clk_i  (clock),
        .rst_ni (i_reset),
        .d_i    (1'b1),
        .q_o    (rst_sync_n)
    );

    sync_2ff #(
        .Width (1)
    ) u_en_sync (
        .clk_i  (clock),
        .rst_ni (i_reset),
        .d_i    (i_enable),
        .q_o    (en_s)
    );

    sync_2ff #(
        .Width (NB_SEL)
    ) u_sel_sync (
        .clk_i  (clock),
        .rst_ni (i_reset),
        .d_i    (i_sel),
        .q_o    (sel_s)
    );

`ifdef LED_VALID_GEN_STEP_EN
    logic step_s;
    logic step_prev_q;

    sync_2ff #(
        .Width (1)
    ) u_step_sync (
        .clk_i  (clock),
        .rst_ni (i_reset),
        .d_i    (i_step),
        .q_o    (step_s)
    );

    always_ff @(posedge clock or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            step_prev_q <= 1'b0;
        end else begin
            step_prev_q <= step_s;
        end
    end

    assign step_rise = step_s & ~step_prev_q;
`else
    logic unused_step;
    assign unused_step = i_step;
    assign step_rise   = 1'b0;
`endif

    state_e              state_q, state_d;
    logic [NB_COUNT-1:0] cnt_q, cnt_d;
    logic [NB_SEL-1:0]   sel_act_q, sel_act_d;
    logic                valid_q, valid_d;
    logic [NB_COUNT-1:0] term;

    always_comb begin
        term = TERM0;
        unique case (sel_act_q)
            2'b00: term = TERM0;
            2'b01: term = TERM1;
            2'b10: term = TERM2;
            2'b11: term = TERM3;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_act_d = sel_act_q;
        valid_d   = 1'b0;
        unique case (state_q)
            ST_STOP: begin
                cnt_d = '0;
                if (en_s) begin
                    state_d   = ST_RUN;
                    sel_act_d = sel_s;
                end else begin
                    valid_d = step_rise;
                end
            end
            ST_RUN: begin
                // Stopping wins over a pending terminal count: no strobe on the way out.
                if (!en_s) begin
                    state_d = ST_STOP;
                    cnt_d   = '0;
                end else if (cnt_q == term) begin
                    cnt_d     = '0;
                    valid_d   = 1'b1;
                    sel_act_d = sel_s;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = ST_STOP;
        endcase
    end

    always_ff @(posedge clock or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q   <= ST_STOP;
            cnt_q     <= '0;
            sel_act_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_act_q <= sel_act_d;
            valid_q   <= valid_d;
        end
    end

    assign o_valid   = valid_q;
    assign o_run     = (state_q == ST_RUN);
    assign o_sel_act = sel_act_q;

endmodule

// File: tb/tb_led_valid_gen.sv
// Directed self-checking bench for led_valid_gen with short periods 4/6/8/10.
module tb_led_valid_gen;

    logic       clock;
    logic       i_reset;
    logic       i_enable;
    logic [1:0] i_sel;
    logic       i_step;
    logic       o_valid;
    logic       o_run;
    logic [1:0] o_sel_act;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef LED_VALID_GEN_STEP_EN
    localparam int StepPulses = 3;
    localparam int HeldPulses = 1;
`else
    localparam int StepPulses = 0;
    localparam int HeldPulses = 0;
`endif

    led_valid_gen #(
        .NB_COUNT (32),
        .PERIOD0  (4),
        .PERIOD1  (6),
        .PERIOD2  (8),
        .PERIOD3  (10)
    ) dut (
        .clock     (clock),
        .i_reset   (i_reset),
        .i_enable  (i_enable),
        .i_sel     (i_sel),
        .i_step    (i_step),
        .o_valid   (o_valid),
        .o_run     (o_run),
        .o_sel_act (o_sel_act)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Returns the number of edges until o_valid is seen high (max_cycles on timeout).
    task automatic wait_valid(input int max_cycles, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (o_valid !== 1'b1 && n < max_cycles);
    endtask

    task automatic count_valid(input int cycles, inout int highs, inout int rises);
        logic prev;
        prev = o_valid;
        for (int k = 0; k < cycles; k++) begin
            tick();
            if (o_valid === 1'b1) begin
                highs++;
                if (prev !== 1'b1) rises++;
            end
            prev = o_valid;
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b0; i_enable = 1'b1; i_sel = 2'b00; i_step = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (o_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", o_valid); else n_pass++;
        n_checks++;
        if (o_run !== 1'b0) $display("FAIL reset_run: got %b want 0", o_run); else n_pass++;
        n_checks++;
        if (o_sel_act !== 2'b00) $display("FAIL reset_sel: got %b want 00", o_sel_act); else n_pass++;
        n_checks++;
        if (dut.cnt_q !== 32'd0) $display("FAIL reset_cnt: got %0d want 0", dut.cnt_q); else n_pass++;
        i_reset = 1'b1;
        tick();
        n_checks++;
        if (o_valid !== 1'b0) $display("FAIL release_valid: got %b want 0", o_valid); else n_pass++;
        tick();
        n_checks++;
        if (o_run !== 1'b0) $display("FAIL run_early: got %b want 0", o_run); else n_pass++;
        tick();
        n_checks++;
        if (o_run !== 1'b1) $display("FAIL run_rise: got %b want 1", o_run); else n_pass++;
    endtask

    task automatic test_periodic();
        int n;
        wait_valid(20, n);
        n_checks++;
        if (n !== 4) $display("FAIL first_pulse: got %0d clocks want 4", n); else n_pass++;
        for (int p = 1; p < 5; p++) begin
            tick();
            n_checks++;
            if (o_valid !== 1'b0) $display("FAIL pulse_width: pulse %0d got %b want 0", p, o_valid);
            else n_pass++;
            wait_valid(20, n);
            n_checks++;
            if (n !== 3) $display("FAIL pulse_spacing: pulse %0d got %0d want 3", p, n);
            else n_pass++;
        end
    endtask

    task automatic test_sel_change();
        int n;
        tick();
        i_sel = 2'b11;
        tick();
        n_checks++;
        if (o_sel_act !== 2'b00) $display("FAIL sel_hold: got %b want 00", o_sel_act); else n_pass++;
        tick();
        n_checks++;
        if (o_sel_act !== 2'b00) $display("FAIL sel_hold2: got %b want 00", o_sel_act); else n_pass++;
        n_checks++;
        if (o_valid !== 1'b0) $display("FAIL sel_early: got %b want 0", o_valid); else n_pass++;
        tick();
        n_checks++;
        if (o_valid !== 1'b1) $display("FAIL sel_old_len: got %b want 1", o_valid); else n_pass++;
        n_checks++;
        if (o_sel_act !== 2'b11) $display("FAIL sel_boundary: got %b want 11", o_sel_act);
        else n_pass++;
        for (int p = 0; p < 2; p++) begin
            wait_valid(30, n);
            n_checks++;
            if (n !== 10) $display("FAIL sel_new_len: got %0d want 10", n); else n_pass++;
        end
        i_sel = 2'b00;
        wait_valid(30, n);
        n_checks++;
        if (n !== 10) $display("FAIL sel_back_len: got %0d want 10", n); else n_pass++;
        n_checks++;
        if (o_sel_act !== 2'b00) $display("FAIL sel_back: got %b want 00", o_sel_act); else n_pass++;
        wait_valid(20, n);
        n_checks++;
        if (n !== 4) $display("FAIL sel_back_period: got %0d want 4", n); else n_pass++;
    endtask

    task automatic test_enable_drop();
        tick();
        i_enable = 1'b0;
        tick();
        n_checks++;
        if (o_run !== 1'b1) $display("FAIL drop_run1: got %b want 1", o_run); else n_pass++;
        tick();
        n_checks++;
        if (dut.cnt_q !== 32'd3) $display("FAIL drop_cnt_term: got %0d want 3", dut.cnt_q);
        else n_pass++;
        tick();
        n_checks++;
        if (o_run !== 1'b0) $display("FAIL drop_run_fall: got %b want 0", o_run); else n_pass++;
        n_checks++;
        if (o_valid !== 1'b0) $display("FAIL drop_no_pulse: got %b want 0", o_valid); else n_pass++;
        n_checks++;
        if (dut.cnt_q !== 32'd0) $display("FAIL drop_cnt: got %0d want 0", dut.cnt_q); else n_pass++;
    endtask

    task automatic test_async_reset();
        int n;
        i_sel = 2'b10; i_enable = 1'b1;
        tick(); tick();
        n_checks++;
        if (o_run !== 1'b0) $display("FAIL restart_early: got %b want 0", o_run); else n_pass++;
        tick();
        n_checks++;
        if (o_sel_act !== 2'b10) $display("FAIL restart_sel: got %b want 10", o_sel_act);
        else n_pass++;
        tick(); tick();
        #2 i_reset = 1'b0;
        #1;
        n_checks++;
        if (o_run !== 1'b0) $display("FAIL async_run: got %b want 0", o_run); else n_pass++;
        n_checks++;
        if (o_sel_act !== 2'b00) $display("FAIL async_sel: got %b want 00", o_sel_act); else n_pass++;
        n_checks++;
        if (o_valid !== 1'b0) $display("FAIL async_valid: got %b want 0", o_valid); else n_pass++;
        tick(); tick();
        i_reset = 1'b1;
        tick();
        n_checks++;
        if (o_valid !== 1'b0) $display("FAIL rerelease_valid: got %b want 0", o_valid); else n_pass++;
        tick(); tick();
        n_checks++;
        if (o_run !== 1'b1) $display("FAIL rerelease_run: got %b want 1", o_run); else n_pass++;
        wait_valid(20, n);
        n_checks++;
        if (n !== 8) $display("FAIL rerelease_pulse: got %0d want 8", n); else n_pass++;
    endtask

    task automatic test_step();
        int n;
        int highs;
        int rises;
        i_enable = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (o_run !== 1'b0) $display("FAIL step_stop: got %b want 0", o_run); else n_pass++;
        repeat (4) tick();
        highs = 0; rises = 0;
        for (int k = 0; k < 3; k++) begin
            i_step = 1'b1;
            count_valid(3, highs, rises);
            i_step = 1'b0;
            count_valid(3, highs, rises);
        end
        count_valid(4, highs, rises);
        n_checks++;
        if (rises !== StepPulses) $display("FAIL step_pulses: got %0d want %0d", rises, StepPulses);
        else n_pass++;
        n_checks++;
        if (highs !== StepPulses) $display("FAIL step_width: got %0d want %0d", highs, StepPulses);
        else n_pass++;
        highs = 0; rises = 0;
        i_step = 1'b1;
        count_valid(12, highs, rises);
        i_step = 1'b0;
        count_valid(6, highs, rises);
        n_checks++;
        if (highs !== HeldPulses) $display("FAIL step_held: got %0d want %0d", highs, HeldPulses);
        else n_pass++;
        i_sel = 2'b00; i_enable = 1'b1;
        wait_valid(20, n);
        n_checks++;
        if (n !== 7) $display("FAIL step_run_start: got %0d want 7", n); else n_pass++;
        highs = 0; rises = 0;
        count_valid(5, highs, rises);
        i_step = 1'b1;
        count_valid(3, highs, rises);
        i_step = 1'b0;
        count_valid(5, highs, rises);
        i_step = 1'b1;
        count_valid(3, highs, rises);
        i_step = 1'b0;
        count_valid(24, highs, rises);
        n_checks++;
        if (highs !== 10) $display("FAIL step_in_run: got %0d want 10", highs); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_sel_change();
        test_enable_drop();
        test_async_reset();
        test_step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete, %0d/%0d done", n_pass, n_checks);
        $fatal(1);
    end

endmodule
